snake_food_ctrl: RTL and testbench
==================================

SNAKE_FOOD_CTRL -- requirements
Module: snake_food_ctrl

Interface
REQ-001 SHALL have parameters: CELL=10 (px per cell); GRID_W=64, GRID_H=48 (cells); MAX_LEN=32 (segments); LFSR_SEED=16'hACE1 (nonzero).
REQ-002 SHALL have ports:
- clk_pix  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- tick  in  1  1-cycle game-step strobe, shared with snake core.
- length  in  8  current segment count from core.
- body_bus_x  in  MAX_LEN*10  packed segment X; seg0 (head) in MSB slice.
- body_bus_y  in  MAX_LEN*9  packed segment Y; seg0 in MSB slice.
- eat_evt  out  1  grow request to core.
- food_x  out  10  food pixel X, multiple of CELL.
- food_y  out  9  food pixel Y, multiple of CELL.
- food_valid  out  1  food placed and displayable.
- self_hit  out  1  sticky head-on-body flag.

Function
REQ-003 SHALL take the head position from the seg0 slices of body_bus_x/y, not from core head_x/head_y, which lag one step.
REQ-004 SHALL clamp the effective length to 1..MAX_LEN: 0 maps to 1, and values above MAX_LEN map to MAX_LEN.
REQ-005 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle. The candidate cell is cx=lfsr[5:0], cy=lfsr[11:6].
REQ-006 SHALL implement the FSM states GEN, CHECK and ARMED, with GEN entered on reset.
REQ-007 GEN behaviour:
- If 1<=cx<=GRID_W-2 and 1<=cy<=GRID_H-2: latch the candidate, set idx=0, go to CHECK.
- Otherwise: stay in GEN and resample next cycle.
REQ-008 CHECK behaviour:
- Compares latched candidate*CELL against segment idx, one segment per cycle.
- On a match: go to GEN.
- At idx=eff_len-1 with no match: register food_x=cx*CELL and food_y=cy*CELL, set food_valid=1, go to ARMED.
- Otherwise: idx increments.
REQ-009 A tick during CHECK SHALL restart the scan at idx=0 on the next cycle, because the body moved.
REQ-010 SHALL register tick_d (tick delayed 1 cycle) and perform all head comparisons on tick_d cycles only.
REQ-011 ARMED behaviour: on tick_d with seg0 equal to (food_x, food_y):
- Clear food_valid next cycle.
- Set eat_pending next cycle.
- Go to GEN.
REQ-012 eat_evt SHALL equal eat_pending. It stays high from the cycle after detection through the next tick cycle inclusive, and clears the cycle after that tick, so the core sees exactly one grow.
REQ-013 The snake core ignores eat_evt at length=MAX_LEN; this block SHALL still complete the eat handshake and regenerate food.
REQ-014 SHALL set self_hit on any tick_d where seg0 equals seg[i] for some 1<=i<eff_len, using a parallel compare; self_hit clears only on reset.
REQ-015 A border clamp by the core (seg0==seg1 after a tick) SHALL set self_hit, which serves as the wall-death indication.
REQ-016 Eat detection and self_hit evaluation on the same tick_d SHALL both take effect.
REQ-017 food_x/food_y SHALL hold their last value while food_valid=0.

Reset
REQ-018 While reset=1 at a clk_pix edge, on the next cycle: state=GEN, lfsr=LFSR_SEED, idx=0, tick_d=0, eat_pending=0, eat_evt=0, food_valid=0, food_x=0, food_y=0, self_hit=0.
REQ-019 Reset asserted in any state, including mid-CHECK or with eat_pending=1, SHALL abort all activity with no residual eat_evt.

Structure
REQ-020 CELL, GRID_W, GRID_H, MAX_LEN, border limits, FSM state encodings and START position SHALL reside in the shared package snake_pkg, used by snake core and this block.
REQ-021 The LFSR SHALL be a sub-module snake_lfsr16 (inputs clk_pix, reset; parameter SEED; output 16-bit state).
REQ-022 Target implementation size is 120-400 lines of RTL.

Verification
REQ-023 Reset then release with length=2: the first candidate in range gives food_valid=1 within 1+2 cycles of entering CHECK, food_x%10==0, 10<=food_x<=620, 10<=food_y<=460.
REQ-024 Force the LFSR candidate onto seg1 (length=2, seg1=(360,280)): FSM returns to GEN and the final food never equals (360,280).
REQ-025 Food at (380,280) and seg0 becomes (380,280) one cycle after tick: eat_evt rises one cycle after tick_d, stays high through the next tick, and falls the cycle after; food_valid=0, then new food.
REQ-026 Tick asserted at idx=5 of a length-20 scan: idx=0 on the following cycle, and the scan runs to completion.
REQ-027 seg0=seg3=(200,100) with length=4 on tick_d: self_hit=1 and remains 1 until reset. Repeating the same stimulus with length=3 leaves self_hit=0.
REQ-028 Assert reset while eat_pending=1: eat_evt=0 on the next cycle and all outputs equal the values in REQ-018.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_pkg : shared geometry, limits and FSM encodings for the game |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package snake_pkg;

  localparam int          CELL      = 10;
  localparam int          GRID_W    = 64;
  localparam int          GRID_H    = 48;
  localparam int          MAX_LEN   = 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Playable cell range; the outer ring of cells is the wall.
  localparam int X_MIN_CELL = 1;
  localparam int X_MAX_CELL = GRID_W - 2;
  localparam int Y_MIN_CELL = 1;
  localparam int Y_MAX_CELL = GRID_H - 2;

  localparam int START_X = (GRID_W / 2) * CELL;
  localparam int START_Y = (GRID_H / 2) * CELL;

  typedef enum logic [1:0] {
    FOOD_GEN   = 2'd0,
    FOOD_CHECK = 2'd1,
    FOOD_ARMED = 2'd2
  } food_state_e;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int max_len);
    logic [7:0] v;
    v = len;
    if (len == 8'd0) begin
      v = 8'd1;
    end else if (int'(len) > max_len) begin
      v = 8'(max_len);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_lfsr16 : free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_pix,
  input  logic        reset,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/snake_food_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_food_ctrl : food placement off the body, eat handshake, and  |
// | sticky self-collision flag.                Rev 1.0                 |
// +--------------------------------------------------------------------+
module snake_food_ctrl #(
  parameter int          CELL      = snake_pkg::CELL,
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter int          MAX_LEN   = snake_pkg::MAX_LEN,
  parameter logic [15:0] LFSR_SEED = snake_pkg::LFSR_SEED
) (
  input  logic                  clk_pix,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [7:0]            length,
  input  logic [MAX_LEN*10-1:0] body_bus_x,
  input  logic [MAX_LEN*9-1:0]  body_bus_y,
  output logic                  eat_evt,
  output logic [9:0]            food_x,
  output logic [8:0]            food_y,
  output logic                  food_valid,
  output logic                  self_hit
);

  import snake_pkg::*;

  localparam int c_idx_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr_hi;
  logic [5:0]         w_cx;
  logic [5:0]         w_cy;
  logic               w_cand_ok;
  logic [5:0]         r_cx;
  logic [5:0]         r_cy;
  logic [9:0]         w_cand_px_x;
  logic [8:0]         w_cand_px_y;
  logic [9:0]         w_seg_x [MAX_LEN];
  logic [8:0]         w_seg_y [MAX_LEN];
  logic [7:0]         w_eff_len;
  logic [c_idx_w-1:0] w_eff_last;
  food_state_e        r_state;
  food_state_e        w_state_nxt;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_nxt;
  logic               r_tick_d;
  logic               w_latch;
  logic               w_food_set;
  logic               w_eat_det;
  logic               w_idx_hit;
  logic               w_head_on_food;
  logic               w_self_det;
  logic [MAX_LEN-1:0] w_body_hit;
  logic               r_eat_pending;
  logic               r_food_valid;
  logic               r_self_hit;
  logic [9:0]         r_food_x;
  logic [8:0]         r_food_y;

  snake_lfsr16 #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk_pix (clk_pix),
    .reset   (reset),
    .o_state (w_lfsr)
  );

  assign w_cx             = w_lfsr[5:0];
  assign w_cy             = w_lfsr[11:6];
  assign w_unused_lfsr_hi = ^w_lfsr[15:12];

  assign w_cand_ok = (int'(w_cx) >= 1) && (int'(w_cx) <= GRID_W - 2) &&
                     (int'(w_cy) >= 1) && (int'(w_cy) <= GRID_H - 2);

  assign w_cand_px_x = 10'(int'(r_cx) * CELL);
  assign w_cand_px_y = 9'(int'(r_cy) * CELL);

  // Segment 0 (the head) occupies the most significant slice of each bus.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
    assign w_seg_x[gi] = body_bus_x[(MAX_LEN-1-gi)*10 +: 10];
    assign w_seg_y[gi] = body_bus_y[(MAX_LEN-1-gi)*9 +: 9];
  end

  assign w_eff_len  = clamp_len(length, MAX_LEN);
  assign w_eff_last = c_idx_w'(w_eff_len - 8'd1);

  assign w_idx_hit = (w_seg_x[r_idx] == w_cand_px_x) && (w_seg_y[r_idx] == w_cand_px_y);

  assign w_body_hit[0] = 1'b0;
  for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_body_cmp
    assign w_body_hit[gi] = (8'(gi) < w_eff_len) &&
                            (w_seg_x[gi] == w_seg_x[0]) &&
                            (w_seg_y[gi] == w_seg_y[0]);
  end

  // Head compares only once the core has applied the step (one cycle after tick).
  assign w_self_det     = r_tick_d && (|w_body_hit);
  assign w_head_on_food = r_tick_d && (w_seg_x[0] == r_food_x) && (w_seg_y[0] == r_food_y);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_food_set  = 1'b0;
    w_eat_det   = 1'b0;
    case (r_state)
      FOOD_GEN: begin
        if (w_cand_ok) begin
          w_latch     = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = FOOD_CHECK;
        end
      end
      FOOD_CHECK: begin
        if (tick) begin
          w_idx_nxt = '0;
        end else if (w_idx_hit) begin
          w_idx_nxt   = '0;
          w_state_nxt = FOOD_GEN;
        end else if (r_idx >= w_eff_last) begin
          // >= so a length that shrank mid-scan still terminates the scan
          w_idx_nxt   = '0;
          w_food_set  = 1'b1;
          w_state_nxt = FOOD_ARMED;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      FOOD_ARMED: begin
        if (w_head_on_food) begin
          w_eat_det   = 1'b1;
          w_state_nxt = FOOD_GEN;
        end
      end
      default: begin
        w_state_nxt = FOOD_GEN;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state       <= FOOD_GEN;
      r_idx         <= '0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_tick_d      <= 1'b0;
      r_eat_pending <= 1'b0;
      r_food_valid  <= 1'b0;
      r_food_x      <= '0;
      r_food_y      <= '0;
      r_self_hit    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tick_d <= tick;
      if (w_latch) begin
        r_cx <= w_cx;
        r_cy <= w_cy;
      end
      if (w_food_set) begin
        r_food_valid <= 1'b1;
        r_food_x     <= w_cand_px_x;
        r_food_y     <= w_cand_px_y;
      end else if (w_eat_det) begin
        r_food_valid <= 1'b0;
      end
      // Held across the next tick so the core samples exactly one grow.
      if (r_eat_pending && tick) begin
        r_eat_pending <= 1'b0;
      end else if (w_eat_det) begin
        r_eat_pending <= 1'b1;
      end
      if (w_self_det) begin
        r_self_hit <= 1'b1;
      end
    end
  end

  assign eat_evt    = r_eat_pending;
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign food_valid = r_food_valid;
  assign self_hit   = r_self_hit;

endmodule
`default_nettype wire

// File: tb/tb_snake_food_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snake_food_ctrl : randomized bench with behavioural food model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_snake_food_ctrl;

  localparam int ML = 32;

  logic            clk_pix = 1'b0;
  logic            reset;
  logic            tick;
  logic [7:0]      length;
  logic [ML*10-1:0] body_bus_x;
  logic [ML*9-1:0]  body_bus_y;
  logic            eat_evt;
  logic [9:0]      food_x;
  logic [8:0]      food_y;
  logic            food_valid;
  logic            self_hit;

  logic [9:0] bx [ML];
  logic [8:0] by [ML];

  int n_checks = 0;
  int n_errors = 0;

  snake_food_ctrl dut (
    .clk_pix    (clk_pix),
    .reset      (reset),
    .tick       (tick),
    .length     (length),
    .body_bus_x (body_bus_x),
    .body_bus_y (body_bus_y),
    .eat_evt    (eat_evt),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .self_hit   (self_hit)
  );

  always #5 clk_pix = ~clk_pix;

  always_comb begin
    for (int i = 0; i < ML; i++) begin
      body_bus_x[(ML-1-i)*10 +: 10] = bx[i];
      body_bus_y[(ML-1-i)*9 +: 9]   = by[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  localparam int PH_SEEK = 0;  // drawing random cells
  localparam int PH_SCAN = 1;  // testing chosen cell against the body
  localparam int PH_SHOW = 2;  // food on screen

  logic [15:0] m_lfsr;
  int  m_phase, m_scan, m_cx, m_cy, m_fx, m_fy, m_eff;
  bit  m_tick_d, m_pend, m_valid, m_hit, m_live = 1'b0;
  bit  m_fed, m_crash;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk_pix) begin
    if (reset) begin
      m_lfsr = 16'hACE1; m_phase = PH_SEEK; m_scan = 0; m_tick_d = 0;
      m_pend = 0; m_valid = 0; m_fx = 0; m_fy = 0; m_hit = 0; m_live = 1;
    end else begin
      m_eff = (length == 0) ? 1 : ((int'(length) > ML) ? ML : int'(length));
      m_crash = 0;
      if (m_tick_d)
        for (int i = 1; i < m_eff; i++)
          if (bx[i] == bx[0] && by[i] == by[0]) m_crash = 1;
      m_fed = m_tick_d && (m_phase == PH_SHOW) &&
              (int'(bx[0]) == m_fx) && (int'(by[0]) == m_fy);
      if (m_pend && tick) m_pend = 0;
      else if (m_fed) m_pend = 1;
      if (m_crash) m_hit = 1;
      if (m_phase == PH_SEEK) begin
        if ((m_lfsr % 64) inside {[1:62]} && ((m_lfsr / 64) % 64) inside {[1:46]}) begin
          m_cx = m_lfsr % 64; m_cy = (m_lfsr / 64) % 64; m_scan = 0; m_phase = PH_SCAN;
        end
      end else if (m_phase == PH_SCAN) begin
        if (tick) m_scan = 0;
        else if (int'(bx[m_scan]) == m_cx * 10 && int'(by[m_scan]) == m_cy * 10) m_phase = PH_SEEK;
        else if (m_scan >= m_eff - 1) begin
          m_fx = m_cx * 10; m_fy = m_cy * 10; m_valid = 1; m_phase = PH_SHOW;
        end else m_scan++;
      end else if (m_fed) begin
        m_valid = 0; m_phase = PH_SEEK;
      end
      m_tick_d = tick;
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge clk_pix) begin
    if (m_live) begin
      check("cmp_eat_evt", eat_evt, m_pend);
      check("cmp_food_valid", food_valid, m_valid);
      check("cmp_food_x", food_x, m_fx);
      check("cmp_food_y", food_y, m_fy);
      check("cmp_self_hit", self_hit, m_hit);
      if (m_valid)
        check("cmp_food_range", (food_x % 10 == 0) && (food_y % 10 == 0) &&
              (food_x >= 10) && (food_x <= 620) && (food_y >= 10) && (food_y <= 460), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic init_body();
    for (int i = 0; i < ML; i++) begin
      bx[i] = 10'(10 * (50 - i));
      by[i] = 9'd100;
    end
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    tick  = 1'b0;
    repeat (2) @(negedge clk_pix);
    init_body();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (food_valid !== 1'b1 && n < 400) begin
      @(negedge clk_pix);
      n++;
    end
    check(name, (n < 400), 1);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk_pix);
    tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; length = 8'd2;
    init_body();
    repeat (3) @(negedge clk_pix);
    check("rst_eat_evt", eat_evt, 0);
    check("rst_food_valid", food_valid, 0);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_self_hit", self_hit, 0);

    // Seed ACE1 is out of range; the next state 59C3 gives cell (3,39).
    reset = 1'b0;
    repeat (3) @(negedge clk_pix);
    check("first_food_pending", food_valid, 0);
    @(negedge clk_pix);
    check("first_food_valid", food_valid, 1);
    check("first_food_x", food_x, 30);
    check("first_food_y", food_y, 390);

    // Eat handshake.
    tick_pulse();
    bx[0] = 10'(m_fx); by[0] = 9'(m_fy);
    check("eat_not_yet", eat_evt, 0);
    @(negedge clk_pix);
    check("eat_evt_rise", eat_evt, 1);
    check("eat_valid_clear", food_valid, 0);
    repeat (5) @(negedge clk_pix);
    check("eat_evt_hold", eat_evt, 1);
    tick = 1'b1;
    check("eat_evt_tick_cycle", eat_evt, 1);
    @(negedge clk_pix);
    tick = 1'b0;
    check("eat_evt_fall", eat_evt, 0);
    wait_valid("refood_timeout");

    // Candidate lands on seg1 and must be rejected.
    hold_reset();
    length = 8'd2; bx[1] = 10'd30; by[1] = 9'd390;
    reset = 1'b0;
    repeat (4) @(negedge clk_pix);
    check("seg1_reject", food_valid, 0);
    wait_valid("reject_timeout");
    check("food_off_seg1", (food_x == 30) && (food_y == 390), 0);

    // Tick at idx=5 of a 20-segment scan restarts it.
    hold_reset();
    length = 8'd20;
    reset = 1'b0;
    repeat (7) @(negedge clk_pix);
    tick_pulse();
    repeat (19) @(negedge clk_pix);
    check("rescan_busy", food_valid, 0);
    @(negedge clk_pix);
    check("rescan_done", food_valid, 1);
    check("rescan_food_x", food_x, 30);

    // Self hit with head on seg3.
    for (int len = 4; len >= 3; len--) begin
      hold_reset();
      length = 8'(len);
      bx[0] = 10'd200; by[0] = 9'd100; bx[3] = 10'd200; by[3] = 9'd100;
      reset = 1'b0;
      repeat (2) @(negedge clk_pix);
      tick_pulse();
      @(negedge clk_pix);
      check("self_hit_eval", self_hit, (len == 4) ? 1 : 0);
      bx[0] = 10'd210;
      repeat (6) @(negedge clk_pix);
      tick_pulse();
      repeat (4) @(negedge clk_pix);
      check("self_hit_sticky", self_hit, (len == 4) ? 1 : 0);
    end

    // Reset while eat is pending.
    hold_reset();
    length = 8'd2;
    reset = 1'b0;
    wait_valid("pend_food_timeout");
    tick_pulse();
    bx[0] = 10'(m_fx); by[0] = 9'(m_fy);
    @(negedge clk_pix);
    check("pend_before_reset", eat_evt, 1);
    reset = 1'b1;
    @(negedge clk_pix);
    check("pend_rst_eat_evt", eat_evt, 0);
    check("pend_rst_valid", food_valid, 0);
    check("pend_rst_x", food_x, 0);
    check("pend_rst_y", food_y, 0);
    check("pend_rst_hit", self_hit, 0);

    // Randomized play.
    init_body();
    length = 8'd8;
    @(negedge clk_pix);
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_pix);
      if (tick) begin
        int pick;
        for (int i = ML - 1; i > 0; i--) begin
          bx[i] = bx[i-1];
          by[i] = by[i-1];
        end
        pick = $urandom_range(0, 5);
        if (pick <= 1 && m_valid) begin
          bx[0] = 10'(m_fx); by[0] = 9'(m_fy);
        end else if (pick == 2) begin
          int k;
          k = $urandom_range(1, 7);
          bx[0] = bx[k]; by[0] = by[k];
        end else begin
          bx[0] = 10'($urandom_range(0, 63) * 10);
          by[0] = 9'($urandom_range(0, 47) * 10);
        end
        if ($urandom_range(0, 7) == 0) length = 8'($urandom_range(0, 40));
      end
      tick  = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 799) == 0);
    end
    tick = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk_pix);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
